m10k_stream_compute: RTL
========================

Name: m10k_stream_compute

Overview:
- Parametrised streaming compute engine between the source M10K and the intermediate M10K.
- On a start pulse it walks `length` consecutive addresses from 0, reads the source (and the intermediate when accumulating), and computes one of four element-wise operations.
- It writes each result back to the intermediate M10K, then pulses done.
- The top-level controller owns start, mode, gain and length.

Parameters:
DATA_W, 8, signed element width of both memories
ADDR_W, 8, address width; memory depth 2**ADDR_W
READ_LAT, 1, M10K read latency in cycles (>=1)
SHIFT, 0, arithmetic right shift applied to src*gain product (0..DATA_W)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  0=COPY, 1=SCALE, 2=ACCUM, 3=CLEAR; latched at start
gain  in  DATA_W  signed multiplier; latched at start
length  in  ADDR_W+1  element count 0..2**ADDR_W; latched at start
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse at end of job
src_rd_addr  out  ADDR_W  source read address
src_rd_data  in  DATA_W  signed source read data, valid READ_LAT cycles after address
int_rd_addr  out  ADDR_W  intermediate read address
int_rd_data  in  DATA_W  signed intermediate read data, same latency
int_wr_addr  out  ADDR_W  intermediate write address
int_wr_data  out  DATA_W  signed intermediate write data
int_wr_en  out  1  intermediate write strobe, one cycle per element

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; index is cleared.
  - All outputs go to 0: busy, done, int_wr_en, all addresses, int_wr_data.
  - Reset mid-job abandons the job: no further writes, and no done pulse.
- FSM states: IDLE, ISSUE, WAIT, COMPUTE, WRITE, FINISH.
- IDLE: on start=1, latch mode/gain/length and clear idx.
  - length==0: go to FINISH.
  - Otherwise go to ISSUE.
- ISSUE: drive src_rd_addr=int_rd_addr=idx.
  - CLEAR goes to WRITE; other modes go to WAIT.
- WAIT: count READ_LAT cycles; addresses held; then go to COMPUTE.
- COMPUTE: register the result from read data.
  - COPY: r = src.
  - SCALE: r = (src*gain) >>> SHIFT, product 2*DATA_W signed.
  - ACCUM: r = int + ((src*gain) >>> SHIFT), computed at 2*DATA_W+1 bits.
  - CLEAR: r = 0.
- WRITE: int_wr_en=1 for exactly one cycle, with int_wr_addr=idx and int_wr_data=r.
  - If idx==length-1, go to FINISH; otherwise idx+1 and go to ISSUE.
- FINISH: done=1 for one cycle, busy=1; next state IDLE with busy=0.
- Timing, with start sampled in cycle T0:
  - Element k is written in cycle T0+1+k*(READ_LAT+3)+READ_LAT+2.
  - done is high in cycle T0+length*(READ_LAT+3)+1.
  - CLEAR writes element k at T0+2+2k; done at T0+2*length+1.
  - length==0: done at T0+1, with no reads or writes.
- Boundary and simultaneous events:
  - start while busy is ignored; latched operands stay stable during the job.
  - length=2**ADDR_W: idx reaches 2**ADDR_W-1 with no wrap; no address beyond the top is issued.
  - Read and write addresses equal within an element: the write occurs after the read data has been consumed, so ACCUM is a safe read-modify-write.
  - start asserted in the FINISH cycle is ignored. It is accepted only in IDLE, i.e. no earlier than the cycle after done.
- Width reduction to DATA_W: see Optional Feature.

Optional Feature:
Macro STREAM_SAT_EN.
- Defined: results are clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1] before the write.
- Undefined: results are truncated to the low DATA_W bits (two's-complement wrap).
- COPY and CLEAR are unaffected either way.

Test Plan:
- Defaults, src[0..3]={5,-3,127,-128}, COPY, length=4 -> int[0..3]={5,-3,127,-128}; 4 int_wr_en pulses at T0+4,8,12,16; done at T0+17.
- SCALE, gain=3, SHIFT=1, src[0]=10, src[1]=-7, length=2 -> int[0]=15, int[1]=-11 (floor of -21/2).
- ACCUM, gain=1, int[0]=100, src[0]=100, length=1:
  - STREAM_SAT_EN defined -> int[0]=127.
  - Undefined -> int[0]=-56.
- CLEAR, length=256 -> all 256 int entries are 0; last write at addr 255; done at T0+513; start pulsed mid-job has no effect.
- length=0 -> done at T0+1; int_wr_en never asserted; busy high only in T1.
- Reset driven low during WAIT of element 2 of an 8-element COPY -> outputs 0 immediately, no further writes, no done; a new start after release runs a full job from addr 0.

Source files
------------

// File: rtl/m10k_stream_compute_if.sv
// Memory-side bundle of the stream engine: source read port plus
// intermediate read and write ports.
interface m10k_stream_compute_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic        [ADDR_W-1:0] src_rd_addr;
    logic signed [DATA_W-1:0] src_rd_data;
    logic        [ADDR_W-1:0] int_rd_addr;
    logic signed [DATA_W-1:0] int_rd_data;
    logic        [ADDR_W-1:0] int_wr_addr;
    logic signed [DATA_W-1:0] int_wr_data;
    logic                     int_wr_en;

    modport master (
        output src_rd_addr,
        input  src_rd_data,
        output int_rd_addr,
        input  int_rd_data,
        output int_wr_addr,
        output int_wr_data,
        output int_wr_en
    );

    modport slave (
        input  src_rd_addr,
        output src_rd_data,
        input  int_rd_addr,
        output int_rd_data,
        input  int_wr_addr,
        input  int_wr_data,
        input  int_wr_en
    );
endinterface

// File: rtl/m10k_stream_compute.sv
// Element-wise stream engine: source M10K -> intermediate M10K.
// Define STREAM_SAT_EN to clamp results instead of wrapping them.
module m10k_stream_compute #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1,
    parameter int SHIFT    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] gain,
    input  logic [ADDR_W:0]          length,
    output logic                     busy,
    output logic                     done,
    m10k_stream_compute_if.master    mem
);

    localparam int PW = 2 * DATA_W;
    localparam int WW = PW + 1;
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [CW-1:0]   WCNT_LAST = CW'(READ_LAT - 1);
    localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);

    localparam logic [1:0] M_COPY  = 2'd0;
    localparam logic [1:0] M_SCALE = 2'd1;
    localparam logic [1:0] M_ACCUM = 2'd2;
    localparam logic [1:0] M_CLEAR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPUTE,
        WRITE,
        FINISH
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        [ADDR_W-1:0] idx_q;
    logic        [1:0]        mode_q;
    logic signed [DATA_W-1:0] gain_q;
    logic        [ADDR_W:0]   len_q;
    logic        [CW-1:0]     wcnt_q;
    logic signed [DATA_W-1:0] res_q;

    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     shf;
    logic signed [WW-1:0]     wide;
    logic signed [DATA_W-1:0] res_d;
    logic                     last;
    logic                     load_res;

`ifdef STREAM_SAT_EN
    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    // In range iff every bit from the result sign upward agrees.
    function automatic logic signed [DATA_W-1:0] narrow(
        input logic signed [WW-1:0] w
    );
        logic [WW-DATA_W:0] hi;
        hi = w[WW-1:DATA_W-1];
        if ((&hi) || !(|hi)) begin
            narrow = w[DATA_W-1:0];
        end else begin
            narrow = w[WW-1] ? MINV : MAXV;
        end
    endfunction
`else
    function automatic logic signed [DATA_W-1:0] narrow(
        input logic signed [WW-1:0] w
    );
        narrow = w[DATA_W-1:0];
    endfunction
`endif

    assign last = ({1'b0, idx_q} == (len_q - LEN_ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                state_d = (mode_q == M_CLEAR) ? WRITE : WAIT;
            end
            WAIT: begin
                if (wcnt_q == WCNT_LAST) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: state_d = WRITE;
            WRITE:   state_d = last ? FINISH : ISSUE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Full-precision product, then the optional accumulate at one extra bit.
    always_comb begin
        prod = PW'(mem.src_rd_data) * PW'(gain_q);
        shf  = prod >>> SHIFT;
        wide = {shf[PW-1], shf};
        res_d = '0;
        unique case (mode_q)
            M_COPY:  res_d = mem.src_rd_data;
            M_SCALE: res_d = narrow(wide);
            M_ACCUM: begin
                wide = wide + {{(WW-DATA_W){mem.int_rd_data[DATA_W-1]}},
                               mem.int_rd_data};
                res_d = narrow(wide);
            end
            M_CLEAR: res_d = '0;
            default: res_d = '0;
        endcase
    end

    assign load_res = (state_q == COMPUTE) ||
                      ((state_q == ISSUE) && (mode_q == M_CLEAR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            mode_q <= '0;
            gain_q <= '0;
            len_q  <= '0;
            wcnt_q <= '0;
            res_q  <= '0;
        end else begin
            if ((state_q == IDLE) && start) begin
                mode_q <= mode;
                gain_q <= gain;
                len_q  <= length;
                idx_q  <= '0;
            end
            if (state_q == ISSUE) begin
                wcnt_q <= '0;
            end else if (state_q == WAIT) begin
                wcnt_q <= wcnt_q + CW'(1);
            end
            if (load_res) begin
                res_q <= res_d;
            end
            // Stop at the last element so a full-depth job never wraps.
            if ((state_q == WRITE) && !last) begin
                idx_q <= idx_q + ADDR_W'(1);
            end
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FINISH);
    assign mem.int_wr_en   = (state_q == WRITE);
    assign mem.src_rd_addr = idx_q;
    assign mem.int_rd_addr = idx_q;
    assign mem.int_wr_addr = idx_q;
    assign mem.int_wr_data = res_q;

endmodule
